// File: rtl/ccw_pkg.sv
// Shared definitions for the CCW channel-program sequencer:
// FSM encoding, CCW field positions, status and result bit indices.
package ccw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_INIT,
        S_XFER,
        S_END,
        S_FINISH
    } state_t;

    localparam int CCW_CMD_LSB = 24;
    localparam int CCW_CC      = 23;
    localparam int CCW_SLI     = 22;
    localparam int CCW_CNT_MSB = 15;

    localparam int ST_DE = 5;
    localparam int ST_UC = 6;
    localparam int ST_UE = 7;

    localparam int FL_IL   = 0;
    localparam int FL_CHK  = 1;
    localparam int FL_INIT = 2;
    localparam int FL_TMO  = 3;

    function automatic logic is_check(input logic [7:0] s);
        return s[ST_UC] | s[ST_UE];
    endfunction

endpackage

// File: rtl/ccw_xfer_gate.sv
// Byte-count gate for both stream directions of one CCW:
// pass-through while count remains, one stop request on overrun.
module ccw_xfer_gate (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_count,
    input  logic        en,
    input  logic [7:0]  host_send_tdata,
    input  logic        host_send_tvalid,
    output logic        host_send_tready,
    output logic [7:0]  chan_send_tdata,
    output logic        chan_send_tvalid,
    input  logic        chan_send_tready,
    input  logic [7:0]  chan_recv_tdata,
    input  logic        chan_recv_tvalid,
    output logic        chan_recv_tready,
    output logic [7:0]  host_recv_tdata,
    output logic        host_recv_tvalid,
    input  logic        host_recv_tready,
    output logic [15:0] cnt,
    output logic        overrun,
    output logic        chan_stop,
    output logic        hs
);

    logic nz;
    logic send_hs;
    logic recv_hs;
    logic stop_req;

    // Gates qualified by remaining count; a send beat blocks a
    // simultaneous receive beat so the count never underflows.
    always_comb begin
        nz               = cnt != 16'd0;
        chan_send_tdata  = host_send_tdata;
        chan_send_tvalid = en & nz & host_send_tvalid;
        host_send_tready = en & nz & chan_send_tready;
        send_hs          = chan_send_tvalid & chan_send_tready;
        host_recv_tdata  = chan_recv_tdata;
        host_recv_tvalid = en & nz & ~send_hs & chan_recv_tvalid;
        chan_recv_tready = en & nz & ~send_hs & host_recv_tready;
        recv_hs          = chan_recv_tvalid & chan_recv_tready;
        hs               = send_hs | recv_hs;
        stop_req         = en & ~nz & ~overrun
                         & (chan_send_tready | chan_recv_tvalid);
    end

    // Byte counter, overrun marker and single stop pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            overrun   <= 1'b0;
            chan_stop <= 1'b0;
        end else begin
            chan_stop <= stop_req;
            if (load) begin
                cnt     <= load_count;
                overrun <= 1'b0;
            end else begin
                if (hs)
                    cnt <= cnt - 16'd1;
                if (stop_req)
                    overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccw_sequencer.sv
// Channel-program sequencer: fetches CCWs, starts the device,
// gates data by count and chains or finishes on ending status.
module ccw_sequencer
    import ccw_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [7:0]            dev_addr,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            result_status,
    output logic [3:0]            result_flags,
    output logic [15:0]           residual,
    output logic [ADDR_WIDTH-1:0] last_ccw_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            chan_address,
    output logic [7:0]            chan_command,
    output logic                  chan_start,
    output logic                  chan_stop,
    input  logic                  chan_active,
    input  logic [7:0]            chan_status_tdata,
    input  logic                  chan_status_tvalid,
    input  logic [7:0]            host_send_tdata,
    input  logic                  host_send_tvalid,
    output logic                  host_send_tready,
    output logic [7:0]            chan_send_tdata,
    output logic                  chan_send_tvalid,
    input  logic                  chan_send_tready,
    input  logic [7:0]            chan_recv_tdata,
    input  logic                  chan_recv_tvalid,
    output logic                  chan_recv_tready,
    output logic [7:0]            host_recv_tdata,
    output logic                  host_recv_tvalid,
    input  logic                  host_recv_tready
);

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  cc;
    logic                  sli;
    logic                  dec_first;
    logic [31:0]           wd;
    logic                  wd_run;
    logic                  wd_hit;
    logic                  gate_load;
    logic                  gate_en;
    logic [15:0]           cnt;
    logic                  overrun;
    logic                  hs;
    logic                  il;
    logic                  uc;
    logic                  unused_rsvd;

    assign unused_rsvd = ^mem_rdata[21:16];

    ccw_xfer_gate u_gate (
        .clk              (clk),
        .reset            (reset),
        .load             (gate_load),
        .load_count       (mem_rdata[CCW_CNT_MSB:0]),
        .en               (gate_en),
        .host_send_tdata  (host_send_tdata),
        .host_send_tvalid (host_send_tvalid),
        .host_send_tready (host_send_tready),
        .chan_send_tdata  (chan_send_tdata),
        .chan_send_tvalid (chan_send_tvalid),
        .chan_send_tready (chan_send_tready),
        .chan_recv_tdata  (chan_recv_tdata),
        .chan_recv_tvalid (chan_recv_tvalid),
        .chan_recv_tready (chan_recv_tready),
        .host_recv_tdata  (host_recv_tdata),
        .host_recv_tvalid (host_recv_tvalid),
        .host_recv_tready (host_recv_tready),
        .cnt              (cnt),
        .overrun          (overrun),
        .chan_stop        (chan_stop),
        .hs               (hs)
    );

    // Gate control, watchdog qualifiers and end-of-CCW evaluation.
    always_comb begin
        gate_load = (state == S_DECODE) && dec_first;
        gate_en   = state == S_XFER;
        wd_run    = (state == S_DECODE) || (state == S_WAIT_INIT)
                 || (state == S_XFER);
        wd_hit    = (TIMEOUT_CYCLES != 0) && (wd == WD_LAST);
        il        = ((cnt != 16'd0) || overrun) && !sli;
        uc        = is_check(result_status);
    end

    // Sequencer FSM with registered outputs; memory data is only
    // valid in the first DECODE cycle, hence dec_first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_rd        <= 1'b0;
            mem_addr      <= '0;
            chan_start    <= 1'b0;
            chan_address  <= '0;
            chan_command  <= '0;
            result_status <= '0;
            result_flags  <= '0;
            residual      <= '0;
            last_ccw_addr <= '0;
            ptr           <= '0;
            cc            <= 1'b0;
            sli           <= 1'b0;
            dec_first     <= 1'b0;
            wd            <= '0;
        end else begin
            done       <= 1'b0;
            mem_rd     <= 1'b0;
            chan_start <= 1'b0;
            if (wd_run && !hs)
                wd <= wd + 32'd1;
            else
                wd <= '0;

            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        ptr          <= prog_addr;
                        mem_addr     <= prog_addr;
                        mem_rd       <= 1'b1;
                        result_flags <= '0;
                        busy         <= 1'b1;
                        state        <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    dec_first <= 1'b1;
                    wd        <= '0;
                    state     <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_first) begin
                        dec_first     <= 1'b0;
                        chan_command  <= mem_rdata[CCW_CMD_LSB +: 8];
                        chan_address  <= dev_addr;
                        cc            <= mem_rdata[CCW_CC];
                        sli           <= mem_rdata[CCW_SLI];
                        last_ccw_addr <= ptr;
                    end
                    if (!chan_active) begin
                        chan_start <= 1'b1;
                        wd         <= '0;
                        state      <= S_ISSUE;
                    end else if (wd_hit) begin
                        result_flags[FL_TMO] <= 1'b1;
                        busy                 <= 1'b0;
                        done                 <= 1'b1;
                        state                <= S_FINISH;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= S_WAIT_INIT;
                end
                S_WAIT_INIT: begin
                    if (chan_status_tvalid) begin
                        result_status <= chan_status_tdata;
                        wd            <= '0;
                        if (chan_status_tdata == 8'h00) begin
                            state <= S_XFER;
                        end else if (chan_status_tdata[ST_DE]) begin
                            state <= S_END;
                        end else begin
                            result_flags[FL_INIT] <= 1'b1;
                            busy                  <= 1'b0;
                            done                  <= 1'b1;
                            state                 <= S_FINISH;
                        end
                    end else if (wd_hit) begin
                        result_flags[FL_TMO] <= 1'b1;
                        busy                 <= 1'b0;
                        done                 <= 1'b1;
                        state                <= S_FINISH;
                    end
                end
                S_XFER: begin
                    if (chan_status_tvalid) begin
                        result_status <= chan_status_tdata;
                        if (chan_status_tdata[ST_DE]) begin
                            wd    <= '0;
                            state <= S_END;
                        end
                    end else if (wd_hit && !hs) begin
                        result_flags[FL_TMO] <= 1'b1;
                        busy                 <= 1'b0;
                        done                 <= 1'b1;
                        state                <= S_FINISH;
                    end
                end
                S_END: begin
                    residual              <= cnt;
                    result_flags[FL_IL]  <= result_flags[FL_IL] | il;
                    result_flags[FL_CHK] <= result_flags[FL_CHK] | uc;
                    wd                    <= '0;
                    if (cc && !il && !uc && (result_flags == 4'd0)) begin
                        ptr      <= ptr + 1'b1;
                        mem_addr <= ptr + 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccw_sequencer.sv
// Directed scoreboard bench for ccw_sequencer: memory model,
// scripted device, byte scoreboard and pulse monitors.
module tb_ccw_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [7:0]  dev_addr = 8'h5A;
    logic        busy;
    logic        done;
    logic [7:0]  result_status;
    logic [3:0]  result_flags;
    logic [15:0] residual;
    logic [7:0]  last_ccw_addr;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  chan_address;
    logic [7:0]  chan_command;
    logic        chan_start;
    logic        chan_stop;
    logic        chan_active = 1'b0;
    logic [7:0]  chan_status_tdata = '0;
    logic        chan_status_tvalid = 1'b0;
    logic [7:0]  host_send_tdata = '0;
    logic        host_send_tvalid = 1'b0;
    logic        host_send_tready;
    logic [7:0]  chan_send_tdata;
    logic        chan_send_tvalid;
    logic        chan_send_tready = 1'b0;
    logic [7:0]  chan_recv_tdata = '0;
    logic        chan_recv_tvalid = 1'b0;
    logic        chan_recv_tready;
    logic [7:0]  host_recv_tdata;
    logic        host_recv_tvalid;
    logic        host_recv_tready = 1'b0;

    logic [31:0] mem [256];
    logic [7:0]  exp_q [$];
    logic [7:0]  fetch_q [$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_start = 0;
    int n_stop = 0;
    int n_done = 0;
    int n_send = 0;
    int n_recv = 0;
    int start_cyc = 0;
    int done_cyc = 0;

    ccw_sequencer #(.ADDR_WIDTH(8), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .go(go), .prog_addr(prog_addr),
        .dev_addr(dev_addr), .busy(busy), .done(done),
        .result_status(result_status), .result_flags(result_flags),
        .residual(residual), .last_ccw_addr(last_ccw_addr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .chan_address(chan_address), .chan_command(chan_command),
        .chan_start(chan_start), .chan_stop(chan_stop),
        .chan_active(chan_active),
        .chan_status_tdata(chan_status_tdata),
        .chan_status_tvalid(chan_status_tvalid),
        .host_send_tdata(host_send_tdata),
        .host_send_tvalid(host_send_tvalid),
        .host_send_tready(host_send_tready),
        .chan_send_tdata(chan_send_tdata),
        .chan_send_tvalid(chan_send_tvalid),
        .chan_send_tready(chan_send_tready),
        .chan_recv_tdata(chan_recv_tdata),
        .chan_recv_tvalid(chan_recv_tvalid),
        .chan_recv_tready(chan_recv_tready),
        .host_recv_tdata(host_recv_tdata),
        .host_recv_tvalid(host_recv_tvalid),
        .host_recv_tready(host_recv_tready)
    );

    always #5 clk = ~clk;

    // Cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // CCW memory with one-cycle read latency.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitors and byte scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (chan_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (chan_stop) n_stop++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (mem_rd) fetch_q.push_back(mem_addr);
            if (chan_send_tvalid && chan_send_tready) begin
                n_send++;
                if (exp_q.size() == 0) chk("send_extra", 1, 0);
                else chk("send_data", chan_send_tdata, exp_q.pop_front());
            end
            if (host_recv_tvalid && host_recv_tready) begin
                n_recv++;
                if (exp_q.size() == 0) chk("recv_extra", 1, 0);
                else chk("recv_data", host_recv_tdata, exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] ccw(input logic [7:0] cmd,
        input logic c, input logic s, input logic [15:0] n);
        return {cmd, c, s, 6'b0, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        n_start = 0; n_stop = 0; n_done = 0; n_send = 0; n_recv = 0;
        exp_q.delete();
        fetch_q.delete();
    endtask

    task automatic start_prog(input logic [7:0] a);
        prog_addr = a;
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int k = 0;
        int n0 = n_start;
        while (n_start == n0 && k < 60) begin
            step();
            k++;
        end
        chk({tag, "_start"}, 32'(n_start != n0), 1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        int n0 = n_done;
        while (n_done == n0 && k < 200) begin
            step();
            k++;
        end
        chk({tag, "_done"}, 32'(n_done != n0), 1);
    endtask

    task automatic status(input logic [7:0] s);
        chan_status_tdata = s;
        chan_status_tvalid = 1'b1;
        step();
        chan_status_tvalid = 1'b0;
        chan_status_tdata = '0;
    endtask

    // Device side: moves up to 'want' bytes, stops early on chan_stop.
    task automatic dev_xfer(input bit rd, input int want);
        int got = 0;
        bit stopped = 0;
        bit hs;
        for (int k = 0; k < 60 && got < want && !stopped; k++) begin
            if (rd) begin
                chan_recv_tvalid = 1'b1;
                chan_recv_tdata = 8'hC0 + 8'(got);
                host_recv_tready = 1'b1;
            end else begin
                chan_send_tready = 1'b1;
                host_send_tvalid = 1'b1;
                host_send_tdata = 8'hA0 + 8'(got);
            end
            #1;
            hs = rd ? (chan_recv_tvalid && chan_recv_tready)
                    : (chan_send_tvalid && chan_send_tready);
            step();
            if (hs) got++;
            if (chan_stop) stopped = 1;
        end
        chan_recv_tvalid = 1'b0;
        chan_send_tready = 1'b0;
        host_send_tvalid = 1'b0;
        host_recv_tready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = ccw(8'h01, 0, 0, 16'd3);
        mem[8'h01] = ccw(8'h02, 0, 0, 16'd2);
        mem[8'h02] = ccw(8'h02, 0, 1, 16'd2);
        mem[8'h03] = ccw(8'h01, 0, 0, 16'd4);
        mem[8'h04] = ccw(8'h01, 0, 1, 16'd0);
        mem[8'h10] = ccw(8'h01, 1, 0, 16'd1);
        mem[8'h11] = ccw(8'h03, 0, 0, 16'd1);
        mem[8'h18] = ccw(8'h01, 1, 0, 16'd2);
        mem[8'h19] = ccw(8'h01, 0, 0, 16'd1);
        mem[8'h20] = ccw(8'h01, 1, 0, 16'd1);
        mem[8'h21] = ccw(8'h01, 0, 0, 16'd1);
        mem[8'h30] = ccw(8'h01, 0, 0, 16'd1);
        mem[8'h40] = ccw(8'h01, 0, 0, 16'd5);

        // reset state, with stream inputs pushed high
        repeat (3) step();
        host_send_tvalid = 1'b1; chan_send_tready = 1'b1;
        chan_recv_tvalid = 1'b1; host_recv_tready = 1'b1;
        #1;
        chk("rst_ctrl", {busy, done, mem_rd, chan_start, chan_stop}, 0);
        chk("rst_result", {result_status, result_flags, residual}, 0);
        chk("rst_addr", {last_ccw_addr, mem_addr,
                         chan_address, chan_command}, 0);
        chk("rst_gates", {chan_send_tvalid, host_send_tready,
                          host_recv_tvalid, chan_recv_tready}, 0);
        host_send_tvalid = 1'b0; chan_send_tready = 1'b0;
        chan_recv_tvalid = 1'b0; host_recv_tready = 1'b0;
        reset = 1'b0;
        step();

        // write CCW, count 3, device takes 3
        clr();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        start_prog(8'h00);
        chk("t1_mem_rd", {mem_rd, busy}, 2'b11);
        wait_start("t1");
        chk("t1_cmd", {chan_address, chan_command}, 16'h5A01);
        status(8'h00);
        dev_xfer(0, 3);
        status(8'h30);
        wait_done("t1");
        chk("t1_status", result_status, 8'h30);
        chk("t1_flags", result_flags, 4'h0);
        chk("t1_resid", residual, 16'd0);
        chk("t1_bytes", {n_send[7:0], 8'(exp_q.size()), n_stop[7:0]},
            24'h030000);
        chk("t1_busy", busy, 0);

        // read CCW, count 2, device offers 4, SLI=0
        clr();
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        start_prog(8'h01);
        wait_start("t2");
        status(8'h00);
        dev_xfer(1, 4);
        status(8'h30);
        wait_done("t2");
        chk("t2_bytes", {n_recv[7:0], 8'(exp_q.size()), n_stop[7:0]},
            24'h020001);
        chk("t2_flags", result_flags, 4'b0001);
        chk("t2_resid", residual, 16'd0);

        // same with SLI=1
        clr();
        exp_q.push_back(8'hC0); exp_q.push_back(8'hC1);
        start_prog(8'h02);
        wait_start("t2b");
        status(8'h00);
        dev_xfer(1, 4);
        status(8'h30);
        wait_done("t2b");
        chk("t2b_bytes", {n_recv[7:0], n_stop[7:0]}, 16'h0201);
        chk("t2b_flags", result_flags, 4'b0000);

        // short write: count 4, device takes 2
        clr();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        start_prog(8'h03);
        wait_start("t3");
        status(8'h00);
        dev_xfer(0, 2);
        status(8'h30);
        wait_done("t3");
        chk("t3_resid", residual, 16'd2);
        chk("t3_flags", result_flags, 4'b0001);
        chk("t3_stop", n_stop, 0);

        // count 0: first request yields a stop, no bytes
        clr();
        start_prog(8'h04);
        wait_start("t4");
        status(8'h00);
        dev_xfer(0, 1);
        status(8'h30);
        wait_done("t4");
        chk("t4_bytes", {n_send[7:0], n_stop[7:0]}, 16'h0001);
        chk("t4_flags", result_flags, 4'b0000);

        // chain 0x10 -> 0x11, second start waits for chan_active low
        clr();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA0);
        start_prog(8'h10);
        wait_start("t5a");
        chan_active = 1'b1;
        status(8'h00);
        dev_xfer(0, 1);
        status(8'h20);
        repeat (8) step();
        chk("t5_held", n_start, 1);
        chk("t5_fetch2", {8'(fetch_q.size()), fetch_q[1]}, 16'h0211);
        chk("t5_cmd2", chan_command, 8'h03);
        chan_active = 1'b0;
        wait_start("t5b");
        status(8'h00);
        dev_xfer(0, 1);
        status(8'h30);
        wait_done("t5");
        chk("t5_counts", {n_start[7:0], n_done[7:0], n_send[7:0]},
            24'h020102);
        chk("t5_last", last_ccw_addr, 8'h11);
        chk("t5_flags", result_flags, 4'b0000);

        // initial status busy -> rejected, no data, no further fetch
        clr();
        start_prog(8'h18);
        wait_start("t6");
        host_send_tvalid = 1'b1; chan_send_tready = 1'b1;
        status(8'h08);
        host_send_tvalid = 1'b0; chan_send_tready = 1'b0;
        wait_done("t6");
        chk("t6_flags", result_flags, 4'b0100);
        chk("t6_status", result_status, 8'h08);
        chk("t6_counts", {n_send[7:0], 8'(fetch_q.size()), n_done[7:0]},
            24'h000101);

        // chained CCW ending with UC: chain stops
        clr();
        exp_q.push_back(8'hA0);
        start_prog(8'h20);
        wait_start("t7");
        status(8'h00);
        dev_xfer(0, 1);
        status(8'h70);
        wait_done("t7");
        chk("t7_flags", result_flags, 4'b0010);
        chk("t7_fetch", fetch_q.size(), 1);
        chk("t7_last", last_ccw_addr, 8'h20);
        chk("t7_status", result_status, 8'h70);

        // silent device: watchdog fires 100 cycles into WAIT_INIT
        clr();
        start_prog(8'h30);
        wait_start("t8");
        wait_done("t8");
        chk("t8_latency", done_cyc - start_cyc, 101);
        chk("t8_flags", result_flags, 4'b1000);

        // reset in the middle of XFER
        clr();
        exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
        start_prog(8'h40);
        wait_start("t9");
        status(8'h00);
        dev_xfer(0, 2);
        chk("t9_busy", busy, 1);
        reset = 1'b1;
        host_send_tvalid = 1'b1; chan_send_tready = 1'b1;
        chan_recv_tvalid = 1'b1; host_recv_tready = 1'b1;
        step();
        chk("t9_ctrl", {busy, done, mem_rd, chan_start, chan_stop}, 0);
        chk("t9_result", {result_status, result_flags, residual}, 0);
        chk("t9_addr", {last_ccw_addr, mem_addr,
                        chan_address, chan_command}, 0);
        chk("t9_gates", {chan_send_tvalid, host_send_tready,
                         host_recv_tvalid, chan_recv_tready}, 0);
        reset = 1'b0;
        host_send_tvalid = 1'b0; chan_send_tready = 1'b0;
        chan_recv_tvalid = 1'b0; host_recv_tready = 1'b0;
        repeat (20) step();
        chk("t9_no_done", n_done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
